// File: rtl/conv_pkg.sv
// Shared types and constants for the conv input-side feeder.
package conv_pkg;

    // Token classes delivered by the upstream parser/FIFO
    typedef enum logic [1:0] {
        TK_NUM  = 2'd0,
        TK_OP   = 2'd1,
        TK_END  = 2'd2,
        TK_RSVD = 2'd3
    } tok_kind_t;

    // ASCII codes of the operators conv understands
    localparam logic [7:0] OP_ADD = 8'd43;
    localparam logic [7:0] OP_SUB = 8'd45;
    localparam logic [7:0] OP_MUL = 8'd42;
    localparam logic [7:0] OP_DIV = 8'd47;

    // Feeder FSM states
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    function automatic logic is_arith_op(input logic [7:0] c);
        return (c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL) || (c == OP_DIV);
    endfunction

endpackage

// File: rtl/conv_feeder_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module conv_feeder_timeout
    import conv_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/conv_feeder.sv
// Token-stream to conv strobe sequencer with BUSY handshake, timeout and
// error reporting. Optional macro SYNTAX_CHECK_EN enables number/operator
// alternation checking.
module conv_feeder
    import conv_pkg::*;
#(
    parameter int unsigned NUM_W   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NUM_W-1:0] TOK_DATA,
    input  logic [1:0]       TOK_KIND,
    input  logic             TOK_STB,
    output logic             TOK_ACK,
    output logic [7:0]       INPUT_SIGN,
    output logic             SIGN_STB,
    output logic [NUM_W-1:0] INPUT_NUMBER,
    output logic             NUMBER_STB,
    input  logic             BUSY,
    output logic             EXPR_DONE,
    output logic             ERROR,
    output logic [CNT_W-1:0] TOK_COUNT
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t     state, state_n;
    tok_kind_t  kind_q, tok_kind;
    logic       ack_n, sign_stb_n, number_stb_n, done_n, error_n;
    logic [CNT_W-1:0] count_n;
    logic       accept, take, legal, seq_ok;
    logic       tmr_load, tmr_dec, tmr_expired;

`ifdef SYNTAX_CHECK_EN
    logic expect_num, expr_empty;
`endif

    assign tok_kind = tok_kind_t'(TOK_KIND);
    // TOK_ACK high means this token was just consumed; upstream still shows it
    // for one more cycle, so it must not be taken twice.
    assign accept = (state == S_IDLE) && TOK_STB && !BUSY && !TOK_ACK;

    conv_feeder_timeout #(.W(TMR_W)) u_timeout (
        .clk       (CLK),
        .rst       (RST),
        .load      (tmr_load),
        .load_value(TMR_W'(TIMEOUT - 1)),
        .dec       (tmr_dec),
        .expired   (tmr_expired)
    );

    // Token legality and (optionally) sequence check
    always_comb begin
        legal = 1'b0;
        case (tok_kind)
            TK_NUM:  legal = 1'b1;
            TK_OP:   legal = is_arith_op(TOK_DATA[7:0]);
            TK_END:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
`ifdef SYNTAX_CHECK_EN
        seq_ok = 1'b0;
        case (tok_kind)
            TK_NUM:  seq_ok = expect_num;
            TK_OP:   seq_ok = !expect_num;
            TK_END:  seq_ok = !expect_num || expr_empty;
            default: seq_ok = 1'b0;
        endcase
`else
        seq_ok = 1'b1;
`endif
    end

    // Next-state and next-output logic; all outputs are registered below
    always_comb begin
        state_n      = state;
        ack_n        = 1'b0;
        done_n       = 1'b0;
        sign_stb_n   = SIGN_STB;
        number_stb_n = NUMBER_STB;
        error_n      = ERROR;
        count_n      = TOK_COUNT;
        take         = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    ack_n = 1'b1;
                    if (legal && seq_ok) begin
                        take    = 1'b1;
                        state_n = S_ISSUE;
                        if ((tok_kind != TK_END) && (TOK_COUNT != '1)) begin
                            count_n = TOK_COUNT + CNT_W'(1);
                        end
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // First ISSUE cycle raises the strobes (one cycle after ACK)
                // and arms the timeout; BUSY is checked before expiry.
                if (!(SIGN_STB || NUMBER_STB)) begin
                    sign_stb_n   = (kind_q != TK_NUM);
                    number_stb_n = (kind_q != TK_OP);
                    tmr_load     = 1'b1;
                end else if (BUSY) begin
                    sign_stb_n   = 1'b0;
                    number_stb_n = 1'b0;
                    state_n      = S_WAIT_DONE;
                end else if (tmr_expired) begin
                    sign_stb_n   = 1'b0;
                    number_stb_n = 1'b0;
                    error_n      = 1'b1;
                    state_n      = S_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!BUSY) begin
                    state_n = S_IDLE;
                    if (kind_q == TK_END) begin
                        done_n  = 1'b1;
                        count_n = '0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= S_IDLE;
            kind_q       <= TK_NUM;
            TOK_ACK      <= 1'b0;
            SIGN_STB     <= 1'b0;
            NUMBER_STB   <= 1'b0;
            INPUT_SIGN   <= '0;
            INPUT_NUMBER <= '0;
            EXPR_DONE    <= 1'b0;
            ERROR        <= 1'b0;
            TOK_COUNT    <= '0;
        end else begin
            state      <= state_n;
            TOK_ACK    <= ack_n;
            SIGN_STB   <= sign_stb_n;
            NUMBER_STB <= number_stb_n;
            EXPR_DONE  <= done_n;
            ERROR      <= error_n;
            TOK_COUNT  <= count_n;
            if (take) begin
                kind_q <= tok_kind;
                if (tok_kind == TK_NUM) INPUT_NUMBER <= TOK_DATA;
                if (tok_kind == TK_OP)  INPUT_SIGN   <= TOK_DATA[7:0];
            end
        end
    end

`ifdef SYNTAX_CHECK_EN
    // Expression grammar tracker, advanced only by forwarded tokens
    always_ff @(posedge CLK) begin
        if (!RST) begin
            expect_num <= 1'b1;
            expr_empty <= 1'b1;
        end else if (take) begin
            case (tok_kind)
                TK_NUM: begin
                    expect_num <= 1'b0;
                    expr_empty <= 1'b0;
                end
                TK_OP:  expect_num <= 1'b1;
                default: begin
                    expect_num <= 1'b1;
                    expr_empty <= 1'b1;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder: stimulus pushes expected strobe events,
// a negedge monitor pops and compares them when each strobe burst ends.
module tb_conv_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] TOK_DATA = '0;
    logic [1:0] TOK_KIND = '0;
    logic       TOK_STB = 1'b0;
    logic       TOK_ACK;
    logic [7:0] INPUT_SIGN;
    logic       SIGN_STB;
    logic [7:0] INPUT_NUMBER;
    logic       NUMBER_STB;
    logic       BUSY = 1'b0;
    logic       EXPR_DONE;
    logic       ERROR;
    logic [7:0] TOK_COUNT;

    conv_feeder #(.NUM_W(8), .CNT_W(8), .TIMEOUT(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TOK_DATA    (TOK_DATA),
        .TOK_KIND    (TOK_KIND),
        .TOK_STB     (TOK_STB),
        .TOK_ACK     (TOK_ACK),
        .INPUT_SIGN  (INPUT_SIGN),
        .SIGN_STB    (SIGN_STB),
        .INPUT_NUMBER(INPUT_NUMBER),
        .NUMBER_STB  (NUMBER_STB),
        .BUSY        (BUSY),
        .EXPR_DONE   (EXPR_DONE),
        .ERROR       (ERROR),
        .TOK_COUNT   (TOK_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  stb;   // {SIGN_STB, NUMBER_STB}
        logic [7:0]  val;
        int unsigned len;   // expected strobe high cycles, 0 = don't care
    } exp_t;

    exp_t sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned ack_count = 0;
    int unsigned done_count = 0;
    int unsigned mode = 0;      // 0 manual BUSY, 1 conv responder, 2 never busy
    int unsigned dly = 0;
    int unsigned busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] stb, input logic [7:0] val, input int unsigned len);
        exp_t e;
        e.stb = stb;
        e.val = val;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_tok(input logic [1:0] k, input logic [7:0] d);
        logic got;
        got = 1'b0;
        TOK_KIND = k;
        TOK_DATA = d;
        TOK_STB  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge CLK);
            #1;
            if (TOK_ACK) got = 1'b1;
        end
        TOK_STB = 1'b0;
        check("tok_ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {8'd0, TOK_ACK, SIGN_STB, NUMBER_STB, EXPR_DONE, ERROR, TOK_COUNT,
                     INPUT_SIGN[3:0], INPUT_NUMBER[3:0]} | {24'd0, INPUT_SIGN[7:4], INPUT_NUMBER[7:4]},
              32'd0);
    endtask

    task automatic do_reset(input string name);
        RST = 1'b0;
        cyc(1);
        check_reset_outputs(name);
        RST = 1'b1;
    endtask

    // conv model: in mode 1 raise BUSY 2 cycles after seeing a strobe, hold 3
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (mode == 1) begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) BUSY = 1'b0;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        BUSY = 1'b1;
                        busy_cnt = 3;
                    end
                end else if ((SIGN_STB || NUMBER_STB) && !BUSY) begin
                    dly = 2;
                end
            end else if (mode == 2) begin
                BUSY = 1'b0;
            end
        end
    end

    // Monitor: count pulses and score each completed strobe burst
    initial begin
        logic [1:0] prev, cur, cap_stb;
        logic [7:0] cap_sign, cap_num;
        int unsigned cap_len;
        exp_t e;
        prev = 2'b00;
        cap_stb = 2'b00;
        cap_sign = '0;
        cap_num = '0;
        cap_len = 0;
        forever begin
            @(negedge CLK);
            cur = {SIGN_STB, NUMBER_STB};
            if (TOK_ACK) ack_count++;
            if (EXPR_DONE) done_count++;
            if (cur != 2'b00 && prev == 2'b00) begin
                cap_stb  = cur;
                cap_sign = INPUT_SIGN;
                cap_num  = INPUT_NUMBER;
                cap_len  = 1;
            end else if (cur != 2'b00) begin
                cap_len++;
            end else if (prev != 2'b00) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got %b expected none", cap_stb);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", {30'd0, cap_stb}, {30'd0, e.stb});
                    if (e.stb == 2'b01) check("number_payload", {24'd0, cap_num}, {24'd0, e.val});
                    if (e.stb == 2'b10) check("sign_payload", {24'd0, cap_sign}, {24'd0, e.val});
                    if (e.len != 0) check("strobe_len", cap_len, e.len);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ack0, done0;

        // Reset state
        cyc(3);
        check_reset_outputs("reset_outputs");
        RST = 1'b1;
        cyc(2);

        // Expression 3 + 4 END with responsive conv
        mode = 1;
        ack0 = ack_count;
        done0 = done_count;
        push(2'b01, 8'd3, 3);
        push(2'b10, 8'd43, 3);
        push(2'b01, 8'd4, 3);
        push(2'b11, 8'd0, 3);
        send_tok(2'd0, 8'd3);  cyc(10);
        check("count_after_3", {24'd0, TOK_COUNT}, 32'd1);
        send_tok(2'd1, 8'd43); cyc(10);
        check("count_after_plus", {24'd0, TOK_COUNT}, 32'd2);
        send_tok(2'd0, 8'd4);  cyc(10);
        check("count_after_4", {24'd0, TOK_COUNT}, 32'd3);
        send_tok(2'd2, 8'd0);  cyc(10);
        check("count_after_end", {24'd0, TOK_COUNT}, 32'd0);
        check("expr_done_pulses", done_count - done0, 32'd1);
        check("ack_pulses", ack_count - ack0, 32'd4);
        check("no_error_expr", {31'd0, ERROR}, 32'd0);

        // BUSY held when token arrives: no ACK until BUSY low is sampled
        mode = 0;
        BUSY = 1'b1;
        ack0 = ack_count;
        push(2'b01, 8'd9, 3);
        TOK_KIND = 2'd0;
        TOK_DATA = 8'd9;
        TOK_STB  = 1'b1;
        cyc(4);
        check("no_ack_while_busy", ack_count - ack0, 32'd0);
        BUSY = 1'b0;
        cyc(1);
        check("ack_after_busy_low", {31'd0, TOK_ACK}, 32'd1);
        TOK_STB = 1'b0;
        mode = 1;
        cyc(10);
        check("count_after_9", {24'd0, TOK_COUNT}, 32'd1);

        // Illegal operator '%': ACKed, not forwarded, ERROR set
        ack0 = ack_count;
        send_tok(2'd1, 8'd37); cyc(3);
        check("bad_op_acked", ack_count - ack0, 32'd1);
        check("bad_op_error", {31'd0, ERROR}, 32'd1);
        check("bad_op_count", {24'd0, TOK_COUNT}, 32'd1);

        do_reset("reset_clears_error");
        cyc(1);

        // Timeout: BUSY never rises, strobe high for 8 cycles
        mode = 2;
        push(2'b01, 8'd5, 8);
        send_tok(2'd0, 8'd5); cyc(12);
        check("timeout_error", {31'd0, ERROR}, 32'd1);
        check("timeout_strobes_low", {30'd0, SIGN_STB, NUMBER_STB}, 32'd0);
        mode = 1;
        done0 = done_count;
        push(2'b11, 8'd0, 3);
        send_tok(2'd2, 8'd0); cyc(10);
        check("after_timeout_done", done_count - done0, 32'd1);
        check("after_timeout_count", {24'd0, TOK_COUNT}, 32'd0);

        // Reset while SIGN_STB is high
        do_reset("reset_before_midstrobe");
        push(2'b01, 8'd2, 3);
        send_tok(2'd0, 8'd2); cyc(10);
        mode = 0;
        BUSY = 1'b0;
        push(2'b10, 8'd45, 0);
        send_tok(2'd1, 8'd45); cyc(2);
        check("sign_stb_high", {31'd0, SIGN_STB}, 32'd1);
        do_reset("reset_mid_strobe");
        mode = 1;
        push(2'b01, 8'd7, 3);
        send_tok(2'd0, 8'd7); cyc(10);
        check("after_reset_count", {24'd0, TOK_COUNT}, 32'd1);
        check("after_reset_error", {31'd0, ERROR}, 32'd0);

        // Two numbers in a row
        do_reset("reset_before_seq");
        ack0 = ack_count;
        push(2'b01, 8'd5, 3);
`ifndef SYNTAX_CHECK_EN
        push(2'b01, 8'd6, 3);
`endif
        send_tok(2'd0, 8'd5); cyc(10);
        send_tok(2'd0, 8'd6); cyc(10);
        check("seq_acks", ack_count - ack0, 32'd2);
`ifdef SYNTAX_CHECK_EN
        check("seq_error", {31'd0, ERROR}, 32'd1);
        check("seq_count", {24'd0, TOK_COUNT}, 32'd1);
`else
        check("seq_error", {31'd0, ERROR}, 32'd0);
        check("seq_count", {24'd0, TOK_COUNT}, 32'd2);
`endif

        cyc(3);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
Sequencing controller that drives the infix-to-postfix converter (conv) input side from a generic token stream.
- Accepts one token at a time: number, operator or end-of-expression.
- Issues each token as a SIGN_STB/NUMBER_STB strobe and runs the BUSY handshake.
- Signals end-of-expression by asserting both strobes together.
- Sits between the token source (parser/FIFO) and conv; reports expression completion and protocol errors.

Parameters:
NUM_W, 8, width of number tokens and INPUT_NUMBER
CNT_W, 8, width of per-expression token counter
TIMEOUT, 256, max cycles to wait for BUSY rise after issuing a strobe

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-low; sampled on rising CLK edge only
TOK_DATA  in  NUM_W  token payload: number value, or ASCII operator in [7:0]
TOK_KIND  in  2  0 = number, 1 = operator, 2 = end of expression, 3 = reserved
TOK_STB  in  1  upstream token valid
TOK_ACK  out  1  one-cycle pulse: token consumed
INPUT_SIGN  out  8  operator to conv
SIGN_STB  out  1  operator strobe to conv
INPUT_NUMBER  out  NUM_W  number to conv
NUMBER_STB  out  1  number strobe to conv
BUSY  in  1  conv busy
EXPR_DONE  out  1  one-cycle pulse: end token fully accepted by conv
ERROR  out  1  sticky error flag
TOK_COUNT  out  CNT_W  tokens forwarded in current expression

Behaviour:
Reset (RST == 0 at a clock edge):
- All outputs go to 0; state goes to IDLE.
- Applies in any state, including mid-handshake. Strobes drop the next edge; no pending token is retained.

States:
- IDLE: if TOK_STB && !BUSY:
  - Latch TOK_DATA/TOK_KIND, pulse TOK_ACK (exactly 1 cycle), go ISSUE.
  - If BUSY == 1, wait; no ACK.
- ISSUE: strobe asserted from the cycle after ACK.
  - kind 0: NUMBER_STB = 1; INPUT_NUMBER = latched value.
  - kind 1: SIGN_STB = 1; INPUT_SIGN = latched value.
  - kind 2: both strobes = 1.
  - Payload outputs stay stable while a strobe is high.
  - On BUSY == 1: drop strobe(s) next cycle, go WAIT_DONE.
  - If a down-counter starting at TIMEOUT reaches 0 first: set ERROR, drop strobes, go IDLE.
- WAIT_DONE: on BUSY == 0, go IDLE.
  - If the latched kind was 2, pulse EXPR_DONE in the same transition cycle and clear TOK_COUNT to 0.

Token checks and counting:
- Operator tokens other than '+' (43), '-' (45), '*' (42) or '/' (47) are ACKed but not forwarded; ERROR is set and the FSM stays in IDLE.
- Kind 3 is treated the same way: ACKed, not forwarded, ERROR set.
- TOK_COUNT increments on entry to ISSUE for kinds 0 and 1 and saturates at all-ones.

Latency and throughput:
- Minimum per token: 1 cycle ACK, then ≥1 cycle strobe, then ≥1 cycle BUSY, then return to IDLE.
- Back-to-back tokens: minimum 4 cycles each.

Sticky and simultaneous events:
- ERROR clears only on reset.
- TOK_STB is ignored while not in IDLE.
- A BUSY rise and the timeout expiring in the same cycle resolve as BUSY wins (no error).

Optional Feature:
SYNTAX_CHECK_EN
- Defined: tracks an expect-number flag, set at reset and after an end token.
  - Number while expecting an operator, operator while expecting a number, or end while expecting a number: token is ACKed, not forwarded, ERROR is set.
  - An empty expression (end token first) is legal and forwarded.
- Undefined: no sequence checking; every legal-kind token is forwarded.

Decomposition:
Shared package conv_pkg holds:
- token kind enum (TK_NUM, TK_OP, TK_END, TK_RSVD);
- operator ASCII constants (OP_ADD = 43, OP_SUB = 45, OP_MUL = 42, OP_DIV = 47);
- FSM state enum (S_IDLE, S_ISSUE, S_WAIT_DONE).

The FSM stays in one module. One natural sub-module: conv_feeder_timeout (loadable down-counter with an expired flag).

Test Plan:
- Tokens 3, '+', 4, END, with a conv model raising BUSY 2 cycles after a strobe and holding it 3 cycles -> NUMBER_STB, SIGN_STB, NUMBER_STB, then both strobes, in that order; 4 TOK_ACK pulses; EXPR_DONE pulses once; TOK_COUNT reaches 3 then 0; ERROR = 0.
- BUSY held high when TOK_STB rises -> no ACK until BUSY falls; ACK the cycle after BUSY = 0 is sampled.
- TIMEOUT = 8, conv model never raises BUSY -> strobe high for 8 cycles, then dropped; ERROR = 1; FSM returns to IDLE and accepts the next token.
- Operator token '%' (37) -> ACKed, no strobe; ERROR = 1; TOK_COUNT unchanged.
- RST = 0 asserted while SIGN_STB is high -> all outputs 0 after the next edge; after release, token 7 is forwarded normally.
- With SYNTAX_CHECK_EN defined, tokens 5 then 6 -> first forwarded, second ACKed but dropped; ERROR = 1; without the macro, both are forwarded.
